// File: rtl/freq_rd_pkg.sv
// freq_rd_pkg: shared sizing helper and FSM encoding for the frequency-counter readout
package freq_rd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CHK = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/freq_frame_reader_sync_rise.sv
// sync_rise: 2-FF synchroniser of an async level followed by a rising-edge pulse
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s1, s2, s3;
  // synchronise the level, then keep one more stage to spot the 0->1 transition
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {din, s1, s2};
  assign rise = s2 & ~s3;
endmodule

// File: rtl/freq_frame_reader.sv
// freq_frame_reader: snapshots counter results and streams them as index-tagged slices plus XOR checksum
module freq_frame_reader
  import freq_rd_pkg::*;
#(
  parameter  int NUM_CH        = 2,
  parameter  int CNT_W         = 32,
  parameter  int SLICE_W       = 8,
  parameter  bit RESTART_STALL = 1'b0,
  localparam int NSLICE        = NUM_CH * CNT_W / SLICE_W,
  localparam int IDX_W         = clog2(NSLICE + 1)
) (
  input  logic                     read_clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*CNT_W-1:0]  cnt_bus,
  input  logic                     cnt_valid,
  input  logic                     rd_en,
  output logic [IDX_W+SLICE_W-1:0] out_word,
  output logic                     out_valid,
  output logic                     frame_done,
  output logic                     overrun
);
  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic                      pending;
  logic                      rise;
  logic [NUM_CH*CNT_W-1:0]   snapshot;
  logic [SLICE_W-1:0]        slice;
  logic [SLICE_W-1:0]        chk;

  sync_rise u_sync (
    .clk  (read_clk),
    .rst_n(rst_n),
    .din  (cnt_valid),
    .rise (rise)
  );

  assign slice = snapshot[int'(idx)*SLICE_W +: SLICE_W];

  // checksum is the XOR of every slice of the held snapshot
  always_comb begin
    chk = '0;
    for (int i = 0; i < NSLICE; i++) chk = chk ^ snapshot[i*SLICE_W +: SLICE_W];
  end

  // capture results, track pending/overrun, and walk the frame one word per enabled cycle
  always_ff @(posedge read_clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      snapshot   <= '0;
      out_word   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_word   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (rise) begin
        if ((state == CHK && rd_en) || (!pending && state == IDLE)) begin
          snapshot <= cnt_bus;
          pending  <= 1'b1;
        end else overrun <= 1'b1;
      end
      case (state)
        IDLE:
          if (pending && rd_en) begin
            state   <= SEND;
            idx     <= '0;
            pending <= 1'b0;
          end
        SEND:
          if (rd_en) begin
            out_word  <= {idx, slice};
            out_valid <= 1'b1;
            idx       <= idx + 1'b1;
            if (idx == IDX_W'(NSLICE - 1)) state <= CHK;
          end else if (RESTART_STALL) idx <= '0;
        CHK:
          if (rd_en) begin
            out_word   <= {IDX_W'(NSLICE), chk};
            out_valid  <= 1'b1;
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (RESTART_STALL) begin
            state <= SEND;
            idx   <= '0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_freq_frame_reader.sv
// tb_freq_frame_reader: directed checks of the readout serializer, pause and restart variants side by side
module tb_freq_frame_reader;
  logic        read_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] cnt_bus = '0;
  logic        cnt_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic [11:0] word0, word1;
  logic        valid0, valid1, done0, done1, ovr0, ovr1;
  int          tests = 0;
  int          fails = 0;
  logic [11:0] frame [9] = '{12'h009, 12'h1EF, 12'h2CD, 12'h3AB, 12'h478,
                             12'h556, 12'h634, 12'h712, 12'h888};

  always #5 read_clk = ~read_clk;

  freq_frame_reader #(.RESTART_STALL(1'b0)) dut0 (
    .read_clk(read_clk), .rst_n(rst_n), .cnt_bus(cnt_bus), .cnt_valid(cnt_valid),
    .rd_en(rd_en), .out_word(word0), .out_valid(valid0), .frame_done(done0), .overrun(ovr0)
  );
  freq_frame_reader #(.RESTART_STALL(1'b1)) dut1 (
    .read_clk(read_clk), .rst_n(rst_n), .cnt_bus(cnt_bus), .cnt_valid(cnt_valid),
    .rd_en(rd_en), .out_word(word1), .out_valid(valid1), .frame_done(done1), .overrun(ovr1)
  );

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic do_reset();
    rd_en = 1'b0;
    cnt_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input logic [63:0] v);
    cnt_bus = v;
    cnt_valid = 1'b1;
    repeat (4) tick();
    cnt_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({word0, valid0, done0, ovr0, word1, valid1, done1, ovr1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got w0=%h v0=%b d0=%b o0=%b w1=%h v1=%b d1=%b o1=%b, want all 0",
               word0, valid0, done0, ovr0, word1, valid1, done1, ovr1);
    end
    do_reset();
  endtask

  task automatic test_frame();
    do_reset();
    load(64'h12345678_ABCDEF09);
    rd_en = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      tests++;
      if ({valid0, word0, done0} !== {1'b1, frame[k], k == 8} ||
          {valid1, word1, done1} !== {1'b1, frame[k], k == 8}) begin
        fails++;
        $display("FAIL frame_word%0d: got %h/%b/%b and %h/%b/%b, want %h/1/%b",
                 k, word0, valid0, done0, word1, valid1, done1, frame[k], k == 8);
      end
    end
    tick();
    tests++;
    if ({valid0, word0, done0, valid1, word1, done1} !== '0) begin
      fails++;
      $display("FAIL frame_end: got v0=%b w0=%h v1=%b w1=%h, want idle zeros", valid0, word0, valid1, word1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    load(64'h12345678_ABCDEF09);
    rd_en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (word0 !== frame[k] || word1 !== frame[k]) begin
        fails++;
        $display("FAIL stall_pre%0d: got %h and %h, want %h", k, word0, word1, frame[k]);
      end
    end
    rd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if ({valid0, word0, valid1, word1} !== '0) begin
        fails++;
        $display("FAIL stall_gap%0d: got v0=%b w0=%h v1=%b w1=%h, want 0", k, valid0, word0, valid1, word1);
      end
    end
    rd_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      tests++;
      if ({valid0, word0, done0} !== (k < 6 ? {1'b1, frame[k+3], k == 5} : 14'd0)) begin
        fails++;
        $display("FAIL resume_word%0d: got %h/%b/%b, want %h", k, word0, valid0, done0, k < 6 ? frame[k+3] : 12'h0);
      end
      tests++;
      if ({valid1, word1, done1} !== {1'b1, frame[k], k == 8}) begin
        fails++;
        $display("FAIL restart_word%0d: got %h/%b/%b, want %h/1/%b", k, word1, valid1, done1, frame[k], k == 8);
      end
    end
    tick();
    tests++;
    if (valid1 !== 1'b0) begin
      fails++;
      $display("FAIL restart_end: got out_valid=%b, want 0", valid1);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    load(64'h12345678_ABCDEF09);
    rd_en = 1'b1;
    tick();
    tests++;
    if (ovr0 !== 1'b0 || ovr1 !== 1'b0) begin
      fails++;
      $display("FAIL overrun_before: got %b %b, want 0", ovr0, ovr1);
    end
    cnt_bus = 64'hFFFF0000_5555AAAA;
    cnt_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 5) cnt_valid = 1'b0;
      tests++;
      if (word0 !== frame[k] || word1 !== frame[k]) begin
        fails++;
        $display("FAIL overrun_word%0d: got %h and %h, want %h", k, word0, word1, frame[k]);
      end
    end
    tests++;
    if (ovr0 !== 1'b1 || ovr1 !== 1'b1) begin
      fails++;
      $display("FAIL overrun_flag: got %b %b, want 1", ovr0, ovr1);
    end
    repeat (3) tick();
    tests++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0 || ovr0 !== 1'b1) begin
      fails++;
      $display("FAIL overrun_no_pending: got v0=%b v1=%b o0=%b, want 0 0 1", valid0, valid1, ovr0);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    load(64'h12345678_ABCDEF09);
    rd_en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (word0 !== frame[k]) begin
        fails++;
        $display("FAIL midreset_pre%0d: got %h, want %h", k, word0, frame[k]);
      end
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if ({word0, valid0, done0, ovr0, word1, valid1, done1, ovr1} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got w0=%h v0=%b w1=%h v1=%b, want 0", word0, valid0, word1, valid1);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      tests++;
      if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
        fails++;
        $display("FAIL midreset_quiet%0d: got v0=%b v1=%b, want 0", k, valid0, valid1);
      end
    end
  endtask

  task automatic test_idle_pulse();
    do_reset();
    load(64'h12345678_ABCDEF09);
    for (int k = 0; k < 10; k++) begin
      tick();
      tests++;
      if (valid0 !== 1'b0 || word1 !== 12'h0) begin
        fails++;
        $display("FAIL idle_quiet%0d: got v0=%b w1=%h, want 0", k, valid0, word1);
      end
    end
    rd_en = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      tests++;
      if ({valid0, word0, done0} !== {1'b1, frame[k], k == 8}) begin
        fails++;
        $display("FAIL idle_frame%0d: got %h/%b/%b, want %h/1/%b", k, word0, valid0, done0, frame[k], k == 8);
      end
    end
    tick();
    tests++;
    if (valid0 !== 1'b0 || done0 !== 1'b0) begin
      fails++;
      $display("FAIL idle_frame_end: got v=%b d=%b, want 0", valid0, done0);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_overrun();
    test_reset_mid_frame();
    test_idle_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
